// File: rtl/synapse_current.sv
// synapse_current: synaptic current integrator feeding the leaky neuron.
// Weighted presynaptic spikes are added to an 8-bit current that leaks by
// current >> DECAY_SHIFT per time step (floored at 1 so it always drains).
// Per-input signed weights are programmable through a simple write port.
module synapse_current #(
    parameter int                 N_IN        = 4,
    parameter int                 DECAY_SHIFT = 3,
    parameter logic signed [7:0]  INIT_WEIGHT = 8'sd32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic [N_IN-1:0]  spike_in,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [7:0]       wr_data,
    output logic [7:0]       current_out,
    output logic             sat
);

    // Sum of up to N_IN signed 8-bit weights, plus a sign bit.
    localparam int SYN_W  = 8 + $clog2(N_IN) + 1;
    // current - leak + syn must not overflow; keep at least 12 bits.
    localparam int NEXT_W = (SYN_W + 2 > 12) ? SYN_W + 2 : 12;

    logic signed [7:0]        r_weight [N_IN];
    logic [7:0]               r_current;
    logic                     r_sat;

    logic [7:0]               w_leak;
    logic signed [SYN_W-1:0]  w_syn;
    logic signed [NEXT_W-1:0] w_next;
    logic                     w_over;
    logic                     w_under;
    logic [7:0]               w_current_d;
    logic                     w_sat_d;

    // Weight registers: written on any edge with a matching in-range address.
    // NOTE: the weights are reset like ordinary flops because INIT_WEIGHT is
    // architectural state after reset; this keeps them out of a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                r_weight[i] <= INIT_WEIGHT;
            end
        end else if (wr_en) begin
            // Addresses >= N_IN match no register and are silently dropped.
            for (int i = 0; i < N_IN; i++) begin
                if (wr_addr == 3'(i)) begin
                    r_weight[i] <= $signed(wr_data);
                end
            end
        end
    end

    // Leak term with a floor of 1 so a small nonzero current still drains.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_leak = r_current >> DECAY_SHIFT;
        if ((r_current != 8'd0) && (w_leak == 8'd0)) begin
            w_leak = 8'd1;
        end
    end

    // Synaptic drive: signed sum of the weights of all inputs spiking now.
    // The register array is read before any same-edge write lands, so a
    // simultaneous write and spike uses the old weight.
    always_comb begin
        w_syn = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spike_in[i]) begin
                w_syn = w_syn + SYN_W'(r_weight[i]);
            end
        end
    end

    // Wide signed next value and its out-of-range flags.
    always_comb begin
        w_next  = $signed({{(NEXT_W-8){1'b0}}, r_current})
                - $signed({{(NEXT_W-8){1'b0}}, w_leak})
                + NEXT_W'(w_syn);
        w_under = w_next[NEXT_W-1];
        w_over  = !w_under && (|w_next[NEXT_W-2:8]);
    end

    // Clamp to 0..255 on a step; hold and clear sat when step is low.
    always_comb begin
        w_current_d = r_current;
        w_sat_d     = 1'b0;
        if (step) begin
            if (w_over) begin
                w_current_d = 8'd255;
                w_sat_d     = 1'b1;
            end else if (w_under) begin
                w_current_d = 8'd0;
                w_sat_d     = 1'b1;
            end else begin
                w_current_d = w_next[7:0];
            end
        end
    end

    // Current and saturation flag registers, updated together.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_current <= 8'd0;
            r_sat     <= 1'b0;
        end else begin
            r_current <= w_current_d;
            r_sat     <= w_sat_d;
        end
    end

    assign current_out = r_current;
    assign sat         = r_sat;

endmodule

// File: tb/tb_synapse_current.sv
// Directed self-checking bench for synapse_current (N_IN=4, DECAY_SHIFT=3,
// INIT_WEIGHT=32). Expected currents are hand-computed.
module tb_synapse_current;

    logic       clk;
    logic       rst_n;
    logic       step;
    logic [3:0] spike_in;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] current_out;
    logic       sat;

    int n_vec = 0;
    int n_err = 0;

    synapse_current #(
        .N_IN        (4),
        .DECAY_SHIFT (3),
        .INIT_WEIGHT (8'sd32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step        (step),
        .spike_in    (spike_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .current_out (current_out),
        .sat         (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive step/spikes, wait for the edge, sample 1 ns later.
    task automatic do_cycle(input logic st, input logic [3:0] sp);
        step     = st;
        spike_in = sp;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        step     = 1'b0;
        spike_in = 4'b0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        do_cycle(1'b0, 4'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 64; k++) begin
            if (current_out == 8'd0) break;
            do_cycle(1'b1, 4'b0);
        end
        check("drain", current_out, 0);
    endtask

    int exp_decay [6]  = '{32, 28, 25, 22, 20, 18};
    int exp_tail  [17] = '{16, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};

    initial begin
        rst_n    = 1'b0;
        step     = 1'b0;
        spike_in = 4'b0;
        wr_en    = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 8'd0;
        #3;
        check("reset_cur", current_out, 0);
        check("reset_sat", sat, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle stepping keeps everything at zero.
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b1, 4'b0);
            check("idle_cur", current_out, 0);
            check("idle_sat", sat, 0);
        end

        // Each weight reads back as 32.
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 4'(1 << i));
            check($sformatf("init_w%0d", i), current_out, 32);
            drain();
        end

        // Single pulse then decay, down through the leak floor to 0.
        for (int k = 0; k < 6; k++) begin
            do_cycle(1'b1, (k == 0) ? 4'b0001 : 4'b0000);
            check($sformatf("decay%0d", k), current_out, exp_decay[k]);
        end
        for (int k = 0; k < 17; k++) begin
            do_cycle(1'b1, 4'b0);
            check($sformatf("tail%0d", k), current_out, exp_tail[k]);
        end

        // Saturation high, then recovery.
        do_cycle(1'b1, 4'hF);
        check("sat1_cur", current_out, 128);
        check("sat1_sat", sat, 0);
        do_cycle(1'b1, 4'hF);
        check("sat2_cur", current_out, 240);
        do_cycle(1'b1, 4'hF);
        check("sat3_cur", current_out, 255);
        check("sat3_sat", sat, 1);
        do_cycle(1'b1, 4'b0);
        check("sat4_cur", current_out, 224);
        check("sat4_sat", sat, 0);
        drain();

        // Same-edge write uses the old weight; next step the new one.
        wr(3'd3, 8'd40);
        do_cycle(1'b1, 4'b1000);
        check("w3_40", current_out, 40);
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        wr_data = 8'hC0;
        do_cycle(1'b1, 4'b0010);
        check("old_w_cur", current_out, 67);
        check("old_w_sat", sat, 0);
        do_cycle(1'b1, 4'b0010);
        check("neg_cur", current_out, 0);
        check("neg_sat", sat, 1);
        do_cycle(1'b1, 4'b0);
        check("neg_clr_sat", sat, 0);

        // Out-of-range address: weights stay 32,-64,32,40.
        wr(3'd5, 8'h01);
        do_cycle(1'b1, 4'hF);
        check("addr5", current_out, 40);
        drain();

        // Hold window with spikes ignored and a write landing mid-window.
        wr(3'd0, 8'd28);
        do_cycle(1'b1, 4'b1101);
        check("to100", current_out, 100);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                wr_en   = 1'b1;
                wr_addr = 3'd2;
                wr_data = 8'd10;
            end
            do_cycle(1'b0, 4'hF);
            check("hold_cur", current_out, 100);
            check("hold_sat", sat, 0);
        end
        do_cycle(1'b1, 4'b0100);
        check("after_hold", current_out, 98);

        // Mid-cycle asynchronous reset at current 200.
        wr(3'd0, 8'd114);
        do_cycle(1'b1, 4'b0001);
        check("to200", current_out, 200);
        #2;
        rst_n    = 1'b0;
        #1;
        check("arst_cur", current_out, 0);
        check("arst_sat", sat, 0);
        step     = 1'b1;
        spike_in = 4'hF;
        @(posedge clk);
        #1;
        check("in_rst_cur", current_out, 0);
        step     = 1'b0;
        spike_in = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b1, 4'b0100);
        check("post_rst_w2", current_out, 32);
        do_cycle(1'b1, 4'hF);
        check("post_rst_all", current_out, 156);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
